// File: rtl/brew_access_ctrl.sv
// rtl/brew_access_ctrl.sv - scan/brew sequencing controller with retry and lockout
module brew_access_ctrl #(
  parameter int TIMEOUT_CYC = 16,
  parameter int MAX_RETRY   = 3,
  parameter int LOCK_CYC    = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cancel,
  input  logic       code_valid,
  input  logic       brew_done,
  output logic       scan_en,
  output logic       brew_go,
  output logic       busy,
  output logic       locked,
  output logic [3:0] fail_cnt
);

  localparam int AW = $clog2(TIMEOUT_CYC);
  localparam int LW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;

  localparam logic [AW-1:0] AT_LAST = AW'(TIMEOUT_CYC - 1);
  localparam logic [LW-1:0] LK_LAST = LW'(LOCK_CYC - 1);
  localparam logic [3:0]    F_MAX   = 4'(MAX_RETRY);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SCAN = 3'd1;
  localparam logic [2:0] GAP  = 3'd2;
  localparam logic [2:0] BREW = 3'd3;
  localparam logic [2:0] LOCK = 3'd4;

  logic [2:0]    state;
  logic [AW-1:0] at_cnt;
  logic [LW-1:0] lk_cnt;
  logic [3:0]    fails;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      at_cnt <= '0;
      lk_cnt <= '0;
      fails  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= SCAN;
            at_cnt <= '0;
          end
        end
        SCAN: begin
          if (cancel) begin
            state <= IDLE;
            fails <= '0;
          end else if (code_valid) begin
            state <= BREW;
            fails <= '0;
          end else if (at_cnt == AT_LAST) begin
            if (fails < F_MAX) fails <= fails + 4'd1;
            // Final allowed attempt timed out: go straight to lockout.
            if (fails + 4'd1 == F_MAX) begin
              state  <= LOCK;
              lk_cnt <= '0;
            end else begin
              state <= GAP;
            end
          end else begin
            at_cnt <= at_cnt + 1'b1;
          end
        end
        GAP: begin
          if (cancel) begin
            state <= IDLE;
            fails <= '0;
          end else begin
            state  <= SCAN;
            at_cnt <= '0;
          end
        end
        BREW: begin
          if (brew_done) state <= IDLE;
        end
        LOCK: begin
          if (lk_cnt == LK_LAST) begin
            state <= IDLE;
            fails <= '0;
          end else begin
            lk_cnt <= lk_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of registered state, so no input-to-output paths exist.
  assign scan_en  = (state == SCAN);
  assign brew_go  = (state == BREW);
  assign busy     = (state != IDLE);
  assign locked   = (state == LOCK);
  assign fail_cnt = fails;

endmodule
